perf_counter_bank: RTL and testbench

- Parametrised bank of hardware performance counters for the pipelined RVX10 core, generalising the fixed cycle/retired-instruction pair.
- NUM_CNT independent counters of CNT_W bits, each driven by a multi-bit event-increment input from the pipeline (cycles, retires, stalls, flushes, ...).
- Adds per-counter enable, global freeze, atomic snapshot for 32-bit readout, preload, sticky overflow flags and an overflow interrupt.
- Sits beside the core top level and is accessed through a simple word-addressed register port.

---
 rtl/perf_counter_bank.sv | 134 +++++++++++++
 tb/tb_perf_counter_bank.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - parametrised bank of event-driven performance counters
//
// Purpose: NUM_CNT counters of CNT_W bits, each advanced by an INC_W-bit event
// increment while both the global gen bit and its ENABLE bit are set. Provides
// atomic snapshot for 32-bit readout, preload, sticky overflow flags and an
// overflow interrupt behind a word-addressed register port.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   event_inc  per-counter increment, slice i = event_inc[i*INC_W +: INC_W]
//   wr_en      register write strobe (wr_addr, wr_data)
//   rd_en      register read strobe (rd_addr)
//   rd_data    registered read data, held until the next accepted read
//   rd_valid   high one cycle after an accepted read
//   irq        registered |(OVF & IRQ_EN)
module perf_counter_bank #(
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 64,
  parameter int INC_W   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CNT*INC_W-1:0] event_inc,
  input  logic                     wr_en,
  input  logic [5:0]               wr_addr,
  input  logic [31:0]              wr_data,
  input  logic                     rd_en,
  input  logic [5:0]               rd_addr,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     irq
);

  localparam int SUM_W = CNT_W + INC_W;
  // Bits of a counter that live in its low register word.
  localparam logic [CNT_W-1:0] LO_MASK = CNT_W'(64'hFFFF_FFFF);

  logic [CNT_W-1:0]   cnt      [NUM_CNT];
  logic [CNT_W-1:0]   cnt_next [NUM_CNT];
  logic [CNT_W-1:0]   snap     [NUM_CNT];
  logic [NUM_CNT-1:0] enable;
  logic [NUM_CNT-1:0] ovf;
  logic [NUM_CNT-1:0] ovf_next;
  logic [NUM_CNT-1:0] irq_en;
  logic [NUM_CNT-1:0] carry;
  logic               gen;
  logic [31:0]        rd_next;

  logic wr_ctrl;
  logic clear_all;
  logic snap_req;
  logic wr_ovf;

  assign wr_ctrl   = wr_en && (wr_addr == 6'h00);
  assign clear_all = wr_ctrl && wr_data[1];
  assign snap_req  = wr_ctrl && wr_data[2];
  assign wr_ovf    = wr_en && (wr_addr == 6'h02);

  // Per-counter next value: clear_all beats preload, preload beats increment.
  always_comb begin
    logic [SUM_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      sum         = SUM_W'(cnt[i]) + SUM_W'(event_inc[i*INC_W +: INC_W]);
      carry[i]    = 1'b0;
      cnt_next[i] = cnt[i];
      if (clear_all) begin
        cnt_next[i] = '0;
      end else if (wr_en && (wr_addr == 6'(8 + 2*i))) begin
        cnt_next[i] = (cnt[i] & ~LO_MASK) | (CNT_W'(wr_data) & LO_MASK);
      end else if ((CNT_W > 32) && wr_en && (wr_addr == 6'(9 + 2*i))) begin
        // Upper write data is truncated to the counter width.
        cnt_next[i] = (cnt[i] & LO_MASK) | CNT_W'({wr_data, 32'h0});
      end else if (gen && enable[i]) begin
        cnt_next[i] = sum[CNT_W-1:0];
        carry[i]    = |sum[SUM_W-1:CNT_W];
      end
    end
  end

  // A fresh overflow wins over a simultaneous write-1-to-clear.
  always_comb begin
    ovf_next = (ovf & ~(wr_ovf ? wr_data[NUM_CNT-1:0] : '0)) | carry;
  end

  // Read mux works on pre-write state; counter words come from snapshots.
  always_comb begin
    logic [63:0] s64;
    s64     = '0;
    rd_next = '0;
    case (rd_addr)
      6'h00:   rd_next = {31'b0, gen};
      6'h01:   rd_next = 32'(enable);
      6'h02:   rd_next = 32'(ovf);
      6'h03:   rd_next = 32'(irq_en);
      default: rd_next = '0;
    endcase
    for (int i = 0; i < NUM_CNT; i++) begin
      s64 = 64'(snap[i]);
      if (rd_addr == 6'(8 + 2*i)) rd_next = s64[31:0];
      if (rd_addr == 6'(9 + 2*i)) rd_next = s64[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i]  <= '0;
        snap[i] <= '0;
      end
      enable   <= '0;
      ovf      <= '0;
      irq_en   <= '0;
      gen      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt[i] <= cnt_next[i];
        if (snap_req) snap[i] <= cnt[i];
      end
      ovf <= ovf_next;
      if (wr_ctrl) gen <= wr_data[0];
      if (wr_en && (wr_addr == 6'h01)) enable <= wr_data[NUM_CNT-1:0];
      if (wr_en && (wr_addr == 6'h03)) irq_en <= wr_data[NUM_CNT-1:0];
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
      irq <= |(ovf & irq_en);
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank
//
// Two instances share one register bus: A (4 x 64-bit, 1-bit events) and
// B (4 x 8-bit, 2-bit events). A cycle-level reference model predicts
// rd_data, rd_valid and irq of both after every clock edge.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [3:0]  ev_a;
  logic [7:0]  ev_b;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, irq_a, irq_b;

  perf_counter_bank #(.NUM_CNT(4), .CNT_W(64), .INC_W(1)) dut_a (
    .clk(clk), .reset(reset), .event_inc(ev_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .irq(irq_a)
  );

  perf_counter_bank #(.NUM_CNT(4), .CNT_W(8), .INC_W(2)) dut_b (
    .clk(clk), .reset(reset), .event_inc(ev_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .irq(irq_b)
  );

  // Reference model state, index 0 = instance A, 1 = instance B.
  logic [63:0] m_cnt  [2][4];
  logic [63:0] m_snap [2][4];
  logic [3:0]  m_en   [2];
  logic [3:0]  m_ovf  [2];
  logic [3:0]  m_ien  [2];
  logic        m_gen  [2];
  logic [31:0] m_rd   [2];
  logic        m_rv   [2];
  logic        m_irq  [2];

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  function automatic logic [63:0] wmask(int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [31:0] m_read(int m, logic [5:0] a);
    logic [63:0] s;
    int k;
    if (a == 6'h00) return {31'b0, m_gen[m]};
    if (a == 6'h01) return {28'b0, m_en[m]};
    if (a == 6'h02) return {28'b0, m_ovf[m]};
    if (a == 6'h03) return {28'b0, m_ien[m]};
    if (a >= 6'd8 && a < 6'd16) begin
      k = (int'(a) - 8) / 2;
      s = m_snap[m][k];
      return a[0] ? s[63:32] : s[31:0];
    end
    return 32'h0;
  endfunction

  // Applies one clock edge of the register-map rules to the model.
  task automatic model_step();
    int          w;
    logic [63:0] msk, old, inc;
    logic [65:0] s;
    logic [3:0]  ovf_n;
    logic        ctrl;
    for (int m = 0; m < 2; m++) begin
      w   = (m == 0) ? 64 : 8;
      msk = wmask(w);
      if (!reset) begin
        for (int i = 0; i < 4; i++) begin
          m_cnt[m][i]  = '0;
          m_snap[m][i] = '0;
        end
        m_en[m] = '0; m_ovf[m] = '0; m_ien[m] = '0; m_gen[m] = 1'b0;
        m_rd[m] = '0; m_rv[m] = 1'b0; m_irq[m] = 1'b0;
      end else begin
        if (rd_en) m_rd[m] = m_read(m, rd_addr);
        m_rv[m]  = rd_en;
        m_irq[m] = |(m_ovf[m] & m_ien[m]);
        ctrl  = wr_en && (wr_addr == 6'h00);
        ovf_n = m_ovf[m] & ~((wr_en && wr_addr == 6'h02) ? wr_data[3:0] : 4'h0);
        for (int i = 0; i < 4; i++) begin
          old = m_cnt[m][i];
          if (ctrl && wr_data[2]) m_snap[m][i] = old;
          inc = (m == 0) ? 64'(ev_a[i]) : 64'(ev_b[2*i +: 2]);
          if (ctrl && wr_data[1])
            m_cnt[m][i] = '0;
          else if (wr_en && int'(wr_addr) == 8 + 2*i)
            m_cnt[m][i] = {old[63:32], wr_data} & msk;
          else if (wr_en && int'(wr_addr) == 9 + 2*i && w > 32)
            m_cnt[m][i] = {wr_data, old[31:0]} & msk;
          else if (m_gen[m] && m_en[m][i]) begin
            s = 66'(old) + 66'(inc);
            m_cnt[m][i] = s[63:0] & msk;
            if (s > 66'(msk)) ovf_n[i] = 1'b1;
          end
        end
        m_ovf[m] = ovf_n;
        if (ctrl) m_gen[m] = wr_data[0];
        if (wr_en && wr_addr == 6'h01) m_en[m]  = wr_data[3:0];
        if (wr_en && wr_addr == 6'h03) m_ien[m] = wr_data[3:0];
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("rd_valid_a", 64'(rd_valid_a), 64'(m_rv[0]));
    chk("rd_data_a",  64'(rd_data_a),  64'(m_rd[0]));
    chk("irq_a",      64'(irq_a),      64'(m_irq[0]));
    chk("rd_valid_b", 64'(rd_valid_b), 64'(m_rv[1]));
    chk("rd_data_b",  64'(rd_data_b),  64'(m_rd[1]));
    chk("irq_b",      64'(irq_b),      64'(m_irq[1]));
  endtask

  task automatic wr(logic [5:0] a, logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(logic [5:0] a);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ev_a = '0; ev_b = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    chk("reset_rd_data", 64'(rd_data_a), 64'h0);
    chk("reset_rd_valid", 64'(rd_valid_a), 64'h0);
    chk("reset_irq", 64'(irq_a), 64'h0);
    reset = 1'b1;

    // Ten single events on counter 0, snapshot, read both halves.
    wr(6'h01, 32'h1);
    wr(6'h00, 32'h1);
    ev_a = 4'h1;
    repeat (10) tick();
    ev_a = 4'h0;
    wr(6'h00, 32'h5);
    rd(6'h08);
    chk("t1_lo", 64'(rd_data_a), 64'd10);
    chk("t1_valid", 64'(rd_valid_a), 64'h1);
    rd(6'h09);
    chk("t1_hi", 64'(rd_data_a), 64'd0);
    tick();
    chk("t1_valid_drop", 64'(rd_valid_a), 64'h0);

    // Preload counter 1 to all ones, one event wraps it and raises irq.
    wr(6'h01, 32'h3);
    wr(6'h03, 32'h2);
    wr(6'h0A, 32'hFFFF_FFFF);
    wr(6'h0B, 32'hFFFF_FFFF);
    ev_a = 4'h2;
    tick();
    ev_a = 4'h0;
    tick();
    chk("t2_irq_set", 64'(irq_a), 64'h1);
    rd(6'h02);
    chk("t2_ovf", 64'(rd_data_a), 64'h2);
    wr(6'h02, 32'h2);
    tick();
    chk("t2_irq_clr", 64'(irq_a), 64'h0);
    wr(6'h00, 32'h5);
    rd(6'h0A);
    chk("t2_cnt1_lo", 64'(rd_data_a), 64'h0);
    rd(6'h0B);
    chk("t2_cnt1_hi", 64'(rd_data_a), 64'h0);

    // clear_all coincident with all-ones events.
    ev_a = 4'hF; ev_b = 8'hFF;
    wr(6'h00, 32'h3);
    ev_a = 4'h0; ev_b = 8'h00;
    wr(6'h00, 32'h5);
    for (int a = 8; a < 16; a++) begin
      rd(6'(a));
      chk("t3_clear_a", 64'(rd_data_a), 64'h0);
      chk("t3_clear_b", 64'(rd_data_b), 64'h0);
    end
    rd(6'h02);

    // ENABLE=0x5, seven event cycles with gen off for three of them.
    wr(6'h01, 32'h5);
    for (int k = 0; k < 7; k++) begin
      ev_a = 4'hF; ev_b = 8'hFF;
      if (k == 1) begin wr_en = 1'b1; wr_addr = 6'h00; wr_data = 32'h0; end
      if (k == 4) begin wr_en = 1'b1; wr_addr = 6'h00; wr_data = 32'h1; end
      tick();
      wr_en = 1'b0;
    end
    ev_a = 4'h0; ev_b = 8'h00;
    wr(6'h00, 32'h5);
    rd(6'h08); chk("t4_c0", 64'(rd_data_a), 64'd4); chk("t4_b_c0", 64'(rd_data_b), 64'd12);
    rd(6'h0A); chk("t4_c1", 64'(rd_data_a), 64'd0);
    rd(6'h0C); chk("t4_c2", 64'(rd_data_a), 64'd4);
    rd(6'h0E); chk("t4_c3", 64'(rd_data_a), 64'd0);

    // Two-bit increments and 8-bit wrap on instance B.
    wr(6'h00, 32'h3);
    wr(6'h01, 32'h1);
    ev_b = 8'h03;
    repeat (4) tick();
    ev_b = 8'h00;
    wr(6'h00, 32'h5);
    rd(6'h08); chk("t5_b_c0", 64'(rd_data_b), 64'd12);
    wr(6'h08, 32'd254);
    ev_b = 8'h03;
    tick();
    ev_b = 8'h00;
    wr(6'h00, 32'h5);
    rd(6'h08); chk("t5_b_wrap", 64'(rd_data_b), 64'd1);
    rd(6'h02); chk("t5_b_ovf0", 64'(rd_data_b[0]), 64'h1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      ev_a    = 4'($urandom());
      ev_b    = 8'($urandom());
      reset   = ($urandom_range(0, 63) != 0);
      rd_en   = 1'($urandom());
      rd_addr = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : 6'($urandom_range(0, 17));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = ($urandom_range(0, 7) == 0) ? 6'($urandom()) : 6'($urandom_range(0, 17));
      wr_data = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom();
      tick();
    end
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; ev_a = '0; ev_b = '0;

    // Reset mid-count with a read issued on the reset edge.
    wr(6'h01, 32'hF);
    wr(6'h03, 32'hF);
    wr(6'h00, 32'h1);
    ev_a = 4'hF; ev_b = 8'hFF;
    repeat (3) tick();
    rd_en = 1'b1; rd_addr = 6'h08; reset = 1'b0;
    tick();
    chk("t6_rv", 64'(rd_valid_a), 64'h0);
    chk("t6_rd", 64'(rd_data_a), 64'h0);
    chk("t6_irq", 64'(irq_a), 64'h0);
    rd_en = 1'b0; reset = 1'b1; ev_a = '0; ev_b = '0;
    wr(6'h00, 32'h4);
    rd(6'h08); chk("t6_cnt0", 64'(rd_data_a), 64'h0);
    rd(6'h01); chk("t6_enable", 64'(rd_data_a), 64'h0);
    rd(6'h02); chk("t6_ovf", 64'(rd_data_a), 64'h0);
    rd(6'h00); chk("t6_ctrl", 64'(rd_data_a), 64'h0);
    chk("t6_irq_after", 64'(irq_a), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
